// File: rtl/tx_os_scheduler_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tx_os_scheduler_if : LTSSM, TX FIFO, OS generator and TX mux signals     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface tx_os_scheduler_if;
  logic       link_active;
  logic       ltssm_os_req;
  logic [1:0] ltssm_os_type;
  logic       ltssm_os_ack;
  logic       ltssm_os_done;
  logic       fifo_has_data;
  logic       pkt_boundary;
  logic       hold_fifo;
  logic       mux_sel;
  logic       os_start;
  logic [1:0] os_type;
  logic       os_busy;
  logic       os_finish;
  logic [2:0] skp_pending;
  logic       skp_overflow;

  // Scheduler view.
  modport master (
    input  link_active, ltssm_os_req, ltssm_os_type, fifo_has_data, pkt_boundary,
           os_busy, os_finish,
    output ltssm_os_ack, ltssm_os_done, hold_fifo, mux_sel, os_start, os_type,
           skp_pending, skp_overflow
  );

  // Surrounding blocks' view.
  modport slave (
    output link_active, ltssm_os_req, ltssm_os_type, fifo_has_data, pkt_boundary,
           os_busy, os_finish,
    input  ltssm_os_ack, ltssm_os_done, hold_fifo, mux_sel, os_start, os_type,
           skp_pending, skp_overflow
  );
endinterface
`default_nettype wire

// File: rtl/tx_os_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tx_os_scheduler : shares the TX datapath between FIFO data and ordered   |
// | sets; arbitrates LTSSM OS requests against periodic SKP insertion.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tx_os_scheduler #(
  parameter int         SKP_INTERVAL = 1180,
  parameter int         CNT_W        = 12,
  parameter int         PENDING_MAX  = 4,
  parameter logic [1:0] SKP_TYPE     = 2'd3
) (
  input  logic               pclk,
  input  logic               reset_n,
  tx_os_scheduler_if.master  bus
);

  localparam logic [CNT_W-1:0] c_TIMER_LAST = CNT_W'(SKP_INTERVAL - 1);
  localparam logic [2:0]       c_PEND_MAX   = 3'(PENDING_MAX);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DATA  = 3'd1,
    ST_GRANT = 3'd2,
    ST_START = 3'd3,
    ST_WAIT  = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_timer;
  logic [2:0]       r_skp_pending;
  logic [2:0]       w_pending_nxt;
  logic             r_skp_overflow;
  logic             w_overflow_nxt;
  logic             r_origin_ltssm;
  logic [1:0]       r_os_type;

  logic w_tick;
  logic w_skp_done;
  logic w_ltssm_req;
  logic w_skp_req;
  logic w_any_req;
  logic w_wait_req;
  logic w_data_ready;

  assign w_tick       = bus.link_active && (r_timer == c_TIMER_LAST);
  assign w_skp_done   = (r_state == ST_WAIT) && bus.os_finish && !r_origin_ltssm;
  assign w_ltssm_req  = bus.ltssm_os_req;
  assign w_skp_req    = bus.link_active && (r_skp_pending != 3'd0);
  assign w_any_req    = w_ltssm_req || w_skp_req;
  assign w_data_ready = bus.link_active && bus.fifo_has_data;
  // Leaving WAIT must see the pending count after this SKP is retired.
  assign w_wait_req   = w_ltssm_req || (bus.link_active && (w_pending_nxt != 3'd0));

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      r_timer <= '0;
    end else if (!bus.link_active || (r_timer == c_TIMER_LAST)) begin
      r_timer <= '0;
    end else begin
      r_timer <= r_timer + 1'b1;
    end
  end

  // A tick and an SKP completion in the same cycle cancel out.
  always_comb begin
    w_pending_nxt  = r_skp_pending;
    w_overflow_nxt = r_skp_overflow;
    if (!bus.link_active) begin
      w_pending_nxt  = 3'd0;
      w_overflow_nxt = 1'b0;
    end else if (w_tick && !w_skp_done) begin
      if (r_skp_pending == c_PEND_MAX) begin
        w_overflow_nxt = 1'b1;
      end else begin
        w_pending_nxt = r_skp_pending + 3'd1;
      end
    end else if (!w_tick && w_skp_done && (r_skp_pending != 3'd0)) begin
      w_pending_nxt = r_skp_pending - 3'd1;
    end
  end

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      r_skp_pending  <= 3'd0;
      r_skp_overflow <= 1'b0;
    end else begin
      r_skp_pending  <= w_pending_nxt;
      r_skp_overflow <= w_overflow_nxt;
    end
  end

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_any_req) begin
          w_state_nxt = ST_GRANT;
        end else if (w_data_ready) begin
          w_state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        if (!bus.link_active) begin
          w_state_nxt = ST_IDLE;
        end else if (w_any_req && (bus.pkt_boundary || !bus.fifo_has_data)) begin
          w_state_nxt = ST_GRANT;
        end
      end
      // A request withdrawn before its ack leaves nothing to send.
      ST_GRANT: begin
        w_state_nxt = w_any_req ? ST_START : ST_IDLE;
      end
      ST_START: begin
        if (!bus.os_busy) begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus.os_finish) begin
          if (w_wait_req) begin
            w_state_nxt = ST_GRANT;
          end else if (w_data_ready) begin
            w_state_nxt = ST_DATA;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      r_origin_ltssm <= 1'b0;
      r_os_type      <= 2'd0;
    end else if (r_state == ST_GRANT) begin
      if (w_ltssm_req) begin
        r_origin_ltssm <= 1'b1;
        r_os_type      <= bus.ltssm_os_type;
      end else if (w_skp_req) begin
        r_origin_ltssm <= 1'b0;
        r_os_type      <= SKP_TYPE;
      end
    end
  end

  assign bus.hold_fifo     = (r_state != ST_DATA);
  assign bus.mux_sel       = (r_state != ST_DATA);
  assign bus.os_start      = (r_state == ST_START) && !bus.os_busy;
  assign bus.os_type       = r_os_type;
  assign bus.ltssm_os_ack  = (r_state == ST_GRANT) && w_ltssm_req;
  assign bus.ltssm_os_done = (r_state == ST_WAIT) && bus.os_finish && r_origin_ltssm;
  assign bus.skp_pending   = r_skp_pending;
  assign bus.skp_overflow  = r_skp_overflow;

endmodule
`default_nettype wire

// File: tb/tb_tx_os_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_tx_os_scheduler : directed bench for tx_os_scheduler (SKP_INTERVAL=16)|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_tx_os_scheduler;
  logic pclk = 1'b0;
  logic reset_n;
  int   total = 0;
  int   bad = 0;
  int   cyc_n = 0;

  tx_os_scheduler_if bus();

  tx_os_scheduler #(
    .SKP_INTERVAL (16),
    .CNT_W        (5),
    .PENDING_MAX  (4),
    .SKP_TYPE     (2'd3)
  ) dut (
    .pclk    (pclk),
    .reset_n (reset_n),
    .bus     (bus.master)
  );

  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Edge k after link_active rises leaves the SKP timer at k mod 16.
  task automatic cyc();
    @(posedge pclk);
    #1;
    cyc_n++;
  endtask

  task automatic run_to(input int n);
    while (cyc_n < n) cyc();
  endtask

  initial begin
    reset_n = 1'b0;
    bus.link_active = 0; bus.ltssm_os_req = 0; bus.ltssm_os_type = 0;
    bus.fifo_has_data = 0; bus.pkt_boundary = 0; bus.os_busy = 0; bus.os_finish = 0;
    cyc(); cyc();
    check("rst_hold", bus.hold_fifo, 1);
    check("rst_sel", bus.mux_sel, 1);
    check("rst_start", bus.os_start, 0);
    check("rst_type", bus.os_type, 0);
    check("rst_ack", bus.ltssm_os_ack, 0);
    check("rst_done", bus.ltssm_os_done, 0);
    check("rst_pend", bus.skp_pending, 0);
    check("rst_ovf", bus.skp_overflow, 0);
    reset_n = 1'b1;
    cyc();
    bus.link_active = 1;
    cyc_n = 0;

    // 1: periodic SKP with no data
    run_to(15);
    check("t1_pend_pre", bus.skp_pending, 0);
    cyc();
    check("t1_pend_16", bus.skp_pending, 1);
    cyc();
    check("t1_grant_hold", bus.hold_fifo, 1);
    check("t1_grant_ack", bus.ltssm_os_ack, 0);
    cyc();
    check("t1_start", bus.os_start, 1);
    check("t1_type", bus.os_type, 3);
    cyc();
    check("t1_wait_start", bus.os_start, 0);
    bus.os_finish = 1;
    #1;
    check("t1_no_done", bus.ltssm_os_done, 0);
    cyc();
    bus.os_finish = 0;
    check("t1_pend_0", bus.skp_pending, 0);
    check("t1_idle_sel", bus.mux_sel, 1);

    // 2: 10-word packet, SKP tick lands on word 3
    run_to(29);
    bus.fifo_has_data = 1;
    cyc();
    for (int w = 1; w <= 10; w++) begin
      bus.pkt_boundary = (w == 10);
      #1;
      check("t2_sel_data", bus.mux_sel, 0);
      if (w == 3) check("t2_pend_w3", bus.skp_pending, 1);
      cyc();
    end
    bus.pkt_boundary = 0;
    check("t2_grant_hold", bus.hold_fifo, 1);
    cyc();
    check("t2_start", bus.os_start, 1);
    check("t2_type", bus.os_type, 3);
    cyc();
    bus.os_finish = 1;
    cyc();
    bus.os_finish = 0;
    bus.fifo_has_data = 0;
    check("t2_resume_sel", bus.mux_sel, 0);
    check("t2_resume_hold", bus.hold_fifo, 0);
    check("t2_pend_0", bus.skp_pending, 0);

    // 3: LTSSM request coincident with SKP tick wins first
    run_to(47);
    bus.ltssm_os_req = 1;
    bus.ltssm_os_type = 2'd1;
    cyc();
    check("t3_ack", bus.ltssm_os_ack, 1);
    check("t3_pend", bus.skp_pending, 1);
    cyc();
    bus.ltssm_os_req = 0;
    check("t3_type1", bus.os_type, 1);
    check("t3_start1", bus.os_start, 1);
    cyc();
    bus.os_finish = 1;
    #1;
    check("t3_done", bus.ltssm_os_done, 1);
    cyc();
    bus.os_finish = 0;
    #1;
    check("t3_done_once", bus.ltssm_os_done, 0);
    check("t3_no_ack", bus.ltssm_os_ack, 0);
    check("t3_pend_kept", bus.skp_pending, 1);
    cyc();
    check("t3_type3", bus.os_type, 3);
    check("t3_start2", bus.os_start, 1);
    cyc();
    bus.os_finish = 1;
    cyc();
    bus.os_finish = 0;
    check("t3_pend_0", bus.skp_pending, 0);
    check("t3_idle_sel", bus.mux_sel, 1);

    // 4: finish withheld across 6 ticks -> saturation
    run_to(64);
    check("t4_pend1", bus.skp_pending, 1);
    run_to(66);
    check("t4_start", bus.os_start, 1);
    run_to(127);
    check("t4_pend4", bus.skp_pending, 4);
    check("t4_ovf_pre", bus.skp_overflow, 0);
    run_to(128);
    check("t4_ovf", bus.skp_overflow, 1);
    check("t4_pend_sat", bus.skp_pending, 4);
    run_to(144);
    check("t4_pend_sat2", bus.skp_pending, 4);
    run_to(159);
    bus.os_finish = 1;
    cyc();
    bus.os_finish = 0;
    check("t4_coincide", bus.skp_pending, 4);
    check("t4_ovf_sticky", bus.skp_overflow, 1);

    // 5: os_busy in START holds off the start pulse
    bus.os_busy = 1;
    cyc();
    check("t5_busy1", bus.os_start, 0);
    cyc();
    check("t5_busy2", bus.os_start, 0);
    cyc();
    check("t5_busy3", bus.os_start, 0);
    cyc();
    bus.os_busy = 0;
    #1;
    check("t5_start", bus.os_start, 1);
    cyc();
    check("t5_one_pulse", bus.os_start, 0);
    bus.os_finish = 1;
    cyc();
    bus.os_finish = 0;
    check("t5_pend3", bus.skp_pending, 3);

    // 6: reset during an LTSSM OS in WAIT
    bus.ltssm_os_req = 1;
    bus.ltssm_os_type = 2'd2;
    #1;
    check("t6_ack", bus.ltssm_os_ack, 1);
    cyc();
    bus.ltssm_os_req = 0;
    check("t6_type2", bus.os_type, 2);
    cyc();
    reset_n = 1'b0;
    bus.os_finish = 1;
    #1;
    check("t6_no_done", bus.ltssm_os_done, 0);
    check("t6_hold", bus.hold_fifo, 1);
    check("t6_sel", bus.mux_sel, 1);
    check("t6_type0", bus.os_type, 0);
    check("t6_pend0", bus.skp_pending, 0);
    check("t6_ovf0", bus.skp_overflow, 0);
    check("t6_start0", bus.os_start, 0);
    cyc();
    bus.os_finish = 0;
    reset_n = 1'b1;
    cyc();
    check("t6_after_done", bus.ltssm_os_done, 0);
    check("t6_after_pend", bus.skp_pending, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
